lsu_mem_responder: RTL and testbench



---
 rtl/lsu_mem_responder.sv | 179 +++++++++++++++++
 tb/tb_lsu_mem_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_responder.sv
// lsu_mem_responder
// Memory-side responder for the LSU 32-bit word port. It holds a word-addressed
// data RAM and serves one access at a time. Each accepted access completes a
// fixed LATENCY cycles later with a one-cycle mem_ready pulse. While the access
// is in flight the responder is busy and does not accept a new request, which
// produces the LSU stall.
// Misaligned or out-of-range accesses still complete with the normal latency.
// They raise mem_err with mem_ready, read as zero, and leave the RAM untouched.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit RAM words
//   LATENCY      cycles from acceptance to response (1..15)
//   BASE_ADDR    byte address of word 0 (word aligned)
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset (RAM contents are kept)
//   mem_req        request valid, held by the LSU until mem_ready
//   mem_we         1 = write, 0 = read
//   mem_addr       byte address
//   mem_writedata  write data
//   mem_readdata   read data, held until the next read response
//   mem_ready      one-cycle completion pulse
//   mem_err        error flag, pulses together with mem_ready
//   busy           high from acceptance through the response cycle
module lsu_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_writedata,
    output logic [31:0] mem_readdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        busy
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 32'd1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT  = (LATENCY >= 32'd2) ? 4'(LATENCY - 32'd2) : 4'd0;
    localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] ram_r [DEPTH_WORDS];

    logic             acc_we_s;
    logic [31:0]      acc_addr_s;
    logic [31:0]      acc_wdata_s;
    logic [31:0]      offset_s;
    logic [IDX_W-1:0] ram_idx_s;
    logic             acc_err_s;
    logic             resp_entry_s;
    logic             ram_we_s;
    logic [31:0]      rd_resp_s;

    // Misalignment is tested on the offset from BASE_ADDR. This matches the
    // test on the raw address because BASE_ADDR is word aligned. The range
    // test covers addresses below the base, whose offset wraps, and word
    // indices past the end of the RAM.
    function automatic logic access_error(input logic [31:0] addr, input logic [31:0] offset);
        return (offset[1:0] != 2'b00) ||
               (addr < BASE_ADDR) ||
               ({2'b00, offset[31:2]} >= DEPTH_W32);
    endfunction

    // Selects the access attributes for the response edge. For LATENCY=1 the
    // response edge is also the acceptance edge, so the live inputs are used
    // in IDLE. In every other state the values latched at acceptance are used.
    always_comb begin
        acc_we_s    = we_r;
        acc_addr_s  = addr_r;
        acc_wdata_s = wdata_r;
        if (state_r == ST_IDLE) begin
            acc_we_s    = mem_we;
            acc_addr_s  = mem_addr;
            acc_wdata_s = mem_writedata;
        end else begin
            acc_we_s    = we_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
        end
    end

    assign offset_s  = acc_addr_s - BASE_ADDR;
    assign ram_idx_s = offset_s[IDX_W+1:2];
    assign acc_err_s = access_error(acc_addr_s, offset_s);

    // True on the edge that moves the FSM into RESP.
    assign resp_entry_s = ((state_r == ST_IDLE) && mem_req && (LATENCY == 32'd1)) ||
                          ((state_r == ST_WAIT) && (cnt_r == 4'd0));

    // No write may land while reset is held, even if a request is pending.
    assign ram_we_s  = resp_entry_s && acc_we_s && !acc_err_s && !reset;
    assign rd_resp_s = acc_err_s ? 32'd0 : ram_r[ram_idx_s];

    // RAM write port: a write commits on its RESP entry edge. The RAM has no reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[ram_idx_s] <= acc_wdata_s;
        end
    end

    // Request sequencing: acceptance, latency countdown and registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            we_r         <= 1'b0;
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            mem_readdata <= 32'd0;
            mem_ready    <= 1'b0;
            mem_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mem_req) begin
                        we_r    <= mem_we;
                        addr_r  <= mem_addr;
                        wdata_r <= mem_writedata;
                        busy    <= 1'b1;
                        if (LATENCY == 32'd1) begin
                            state_r   <= ST_RESP;
                            mem_ready <= 1'b1;
                            mem_err   <= acc_err_s;
                            if (!acc_we_s) begin
                                mem_readdata <= rd_resp_s;
                            end
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r   <= ST_RESP;
                        mem_ready <= 1'b1;
                        mem_err   <= acc_err_s;
                        if (!acc_we_s) begin
                            mem_readdata <= rd_resp_s;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    // A request held high here is not accepted. It is seen again in IDLE.
                    state_r   <= ST_IDLE;
                    mem_ready <= 1'b0;
                    mem_err   <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_ready <= 1'b0;
                    mem_err   <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Testbench for lsu_mem_responder (LATENCY=2, BASE_ADDR=0, DEPTH_WORDS=1024).
// The driver behaves like the LSU. It holds mem_req until mem_ready and pushes
// each expected response into a scoreboard queue. A monitor on the falling
// edge checks every cycle: mem_ready, busy, mem_err and the held mem_readdata.
// These are checked against a reference model built from a word array and
// the acceptance cycle of the current access.
module tb_lsu_mem_responder;

    localparam int          L     = 2;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_ready;
    logic        mem_err;
    logic        busy;

    lsu_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (L),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_ready     (mem_ready),
        .mem_err       (mem_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic        err;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mem_model [int];
    int          written[$];
    int          acc_cyc = -100;
    logic [31:0] exp_rd  = 32'd0;
    int          n_cmp   = 0;
    int          n_bad   = 0;

    function automatic logic model_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE) || (((a - BASE) / 32'd4) >= 32'(DEPTH));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: derives the expected outputs for this cycle from the acceptance cycle and the model.
    always @(negedge clk) begin
        logic er;
        logic eb;
        logic e_err;
        exp_t e;
        er    = (cyc == acc_cyc + L - 1);
        eb    = (cyc >= acc_cyc) && (cyc <= acc_cyc + L - 1);
        e_err = 1'b0;
        if (er) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_empty: response expected with no queued access (cycle %0d)", cyc);
            end else begin
                e     = sbq.pop_front();
                e_err = e.err;
                if (!e.we) begin
                    exp_rd = e.rdata;
                end else if (!e.err) begin
                    mem_model[int'((e.addr - BASE) >> 2)] = e.data;
                end
            end
        end
        check("mem_ready", 32'(mem_ready), 32'(er));
        check("busy", 32'(busy), 32'(eb));
        check("mem_err", 32'(mem_err), 32'(e_err));
        check("mem_readdata", mem_readdata, exp_rd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        mem_req = 1'b0;
        mem_we  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        acc_cyc = -100;
        sbq.delete();
        exp_rd  = 32'd0;
        reset   = 1'b1;
        mem_req = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    // One LSU access. It returns just after the RESP exit edge, with mem_req
    // still high across that edge. 'disturb' changes the inputs while the
    // access is in WAIT.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input bit disturb);
        exp_t e;
        int   t;
        e.we    = we;
        e.addr  = addr;
        e.data  = data;
        e.err   = model_err(addr);
        e.rdata = 32'd0;
        if (!we && !e.err && mem_model.exists(int'((addr - BASE) >> 2))) begin
            e.rdata = mem_model[int'((addr - BASE) >> 2)];
        end
        mem_req       = 1'b1;
        mem_we        = we;
        mem_addr      = addr;
        mem_writedata = data;
        acc_cyc       = cyc + 1;
        sbq.push_back(e);
        tick();
        if (disturb) begin
            mem_addr      = addr ^ 32'h0000_0030;
            mem_writedata = ~data;
            mem_we        = ~we;
        end
        t = 0;
        while (mem_ready !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        if (t >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: no mem_ready within 20 cycles for addr %h", addr);
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0;
        int          sel;
        int          w;
        logic        rwe;
        logic [31:0] a;
        logic [31:0] vec_data [4];
        vec_data[0] = 32'h1234_5678;
        vec_data[1] = 32'h9ABC_DEF0;
        vec_data[2] = 32'h0BAD_F00D;
        vec_data[3] = 32'hCAFE_BABE;

        reset         = 1'b1;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = 32'd0;
        mem_writedata = 32'd0;
        repeat (3) tick();
        reset = 1'b0;
        idle(1);

        // Known prior contents
        access(1'b1, 32'h10, 32'h0000_5A5A, 1'b0);
        access(1'b1, 32'h00, 32'hA5A5_0001, 1'b0);
        idle(1);

        // Reset during WAIT of a write: no commit
        do_reset(1);
        mem_req       = 1'b1;
        mem_we        = 1'b1;
        mem_addr      = 32'h10;
        mem_writedata = 32'hDEAD_BEEF;
        tick();
        check("busy_in_wait", 32'(busy), 32'd1);
        do_reset(1);
        idle(1);
        access(1'b0, 32'h10, 32'd0, 1'b0);

        // Scalar write then read
        access(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        access(1'b0, 32'h10, 32'd0, 1'b0);

        // Vector write/read, back to back
        t0 = cyc;
        for (int i = 0; i < 4; i++) access(1'b1, 32'h20 + 32'(4 * i), vec_data[i], 1'b0);
        check("vec_write_span", 32'(cyc - t0), 32'(4 * (L + 1)));
        t0 = cyc;
        for (int i = 0; i < 4; i++) access(1'b0, 32'h20 + 32'(4 * i), 32'd0, 1'b0);
        check("vec_read_span", 32'(cyc - t0), 32'(4 * (L + 1)));
        idle(1);

        // Misaligned read
        access(1'b0, 32'h13, 32'd0, 1'b0);
        // Out-of-range write, then word 0 unchanged
        access(1'b1, 32'h1000, 32'h1111_1111, 1'b0);
        access(1'b0, 32'h00, 32'd0, 1'b0);
        // Inputs changed during WAIT are ignored
        access(1'b0, 32'h10, 32'd0, 1'b1);
        idle(2);

        // Randomized accesses
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 9));
            rwe = 1'($urandom_range(0, 1));
            if (sel == 0) begin
                a = 32'($urandom_range(0, DEPTH - 1) * 4) | 32'($urandom_range(1, 3));
            end else if (sel == 1) begin
                a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255) * 4);
            end else if (!rwe && written.size() > 0) begin
                a = BASE + 32'(written[$urandom_range(0, written.size() - 1)] * 4);
            end else begin
                rwe = 1'b1;
                w   = int'($urandom_range(0, DEPTH - 1));
                a   = BASE + 32'(w * 4);
                written.push_back(w);
            end
            access(rwe, a, $urandom(), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(3);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
